// File: rtl/issue_scheduler.sv
// Oldest-first issue scheduler that shadows a compacting issue queue's ready/tag state.
// Define ISSUE_BYPASS_EN to let a same-cycle wakeup make a waiting slot eligible immediately.
module issue_scheduler #(
   parameter int Size     = 4,
   parameter int Ports    = 2,
   parameter int TagWidth = 4,
   parameter int Latency  = 1
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic [$clog2(Size+1)-1:0]                           i_size,
   input  logic                                                i_push,
   input  logic                                                i_push_rdy,
   input  logic [TagWidth-1:0]                                 i_push_tag,
   input  logic                                                i_wake_valid,
   input  logic [TagWidth-1:0]                                 i_wake_tag,
   input  logic [Ports-1:0]                                    i_issue_ready,
   output logic [Size-1:0]                                     o_pop,
   output logic [Ports-1:0]                                    o_issue_valid,
   output logic [Ports-1:0][((Size > 1) ? $clog2(Size) : 1)-1:0] o_issue_slot
);

   localparam int SizeW = $clog2(Size + 1);
   localparam int SlotW = (Size > 1) ? $clog2(Size) : 1;
   localparam int CntW  = (Latency > 1) ? $clog2(Latency) : 1;

   logic [Size-1:0]     rdy_reg;
   logic [Size-1:0]     rdy_next;
   logic [TagWidth-1:0] wtag_reg  [Size];
   logic [TagWidth-1:0] wtag_next [Size];
   logic [CntW-1:0]     bcnt_reg  [Ports];

   logic [Size-1:0]     wake_hit;
   logic [Size-1:0]     eligible;
   logic [Size-1:0]     survive;
   logic [SizeW-1:0]    rank [Size];
   logic [SizeW-1:0]    push_idx;
   logic                push_woken;
   logic [Ports-1:0]    port_free;
   logic [Ports-1:0]    grant_valid;
   logic [SlotW-1:0]    grant_slot [Ports];
   logic [Ports-1:0]    fire;

   // Per-slot wakeup match and eligibility
   for (genvar gi = 0; gi < Size; gi++) begin : g_slot
      assign wake_hit[gi] = i_wake_valid && !rdy_reg[gi] && (wtag_reg[gi] == i_wake_tag);
`ifdef ISSUE_BYPASS_EN
      assign eligible[gi] = (SizeW'(gi) < i_size) && (rdy_reg[gi] || wake_hit[gi]);
`else
      assign eligible[gi] = (SizeW'(gi) < i_size) && rdy_reg[gi];
`endif
   end

   for (genvar gi = 0; gi < Ports; gi++) begin : g_free
      assign port_free[gi] = (bcnt_reg[gi] == '0);
   end

   // The k-th lowest free port takes the k-th lowest eligible slot.
   always_comb begin
      logic [Size-1:0] taken;
      logic            found;
      taken       = '0;
      found       = 1'b0;
      grant_valid = '0;
      for (int p = 0; p < Ports; p++) begin
         grant_slot[p] = '0;
      end
      for (int p = 0; p < Ports; p++) begin
         found = 1'b0;
         if (port_free[p]) begin
            for (int i = 0; i < Size; i++) begin
               if (!found && eligible[i] && !taken[i]) begin
                  found          = 1'b1;
                  taken[i]       = 1'b1;
                  grant_valid[p] = 1'b1;
                  grant_slot[p]  = SlotW'(i);
               end
            end
         end
      end
   end

   // Offers, fires and the pop mask are all silenced while reset is asserted.
   always_comb begin
      o_pop         = '0;
      o_issue_valid = '0;
      o_issue_slot  = '0;
      fire          = '0;
      if (!rst) begin
         o_issue_valid = grant_valid;
         for (int p = 0; p < Ports; p++) begin
            o_issue_slot[p] = grant_slot[p];
            fire[p]         = grant_valid[p] && i_issue_ready[p];
            if (fire[p]) begin
               o_pop[grant_slot[p]] = 1'b1;
            end
         end
      end
   end

   // Rank of each survivor gives its compacted position; the survivor count is the append point.
   always_comb begin
      logic [SizeW-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < Size; i++) begin
         survive[i] = (SizeW'(i) < i_size) && !o_pop[i];
         rank[i]    = cnt;
         if (survive[i]) begin
            cnt = cnt + SizeW'(1);
         end
      end
      push_idx = cnt;
   end

   assign push_woken = i_wake_valid && (i_push_tag == i_wake_tag);

   // Pushes into a full queue with nothing popping find no matching slot and are dropped.
   always_comb begin
      rdy_next = '0;
      for (int j = 0; j < Size; j++) begin
         wtag_next[j] = '0;
         for (int i = 0; i < Size; i++) begin
            if (survive[i] && (rank[i] == SizeW'(j))) begin
               rdy_next[j]  = rdy_reg[i] || wake_hit[i];
               wtag_next[j] = wtag_reg[i];
            end
         end
         if (i_push && (push_idx == SizeW'(j))) begin
            rdy_next[j]  = i_push_rdy || push_woken;
            wtag_next[j] = i_push_tag;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdy_reg <= '0;
         for (int i = 0; i < Size; i++) begin
            wtag_reg[i] <= '0;
         end
      end else begin
         rdy_reg <= rdy_next;
         for (int i = 0; i < Size; i++) begin
            wtag_reg[i] <= wtag_next[i];
         end
      end
   end

   // A port stays busy for Latency-1 cycles after each fire.
   for (genvar gi = 0; gi < Ports; gi++) begin : g_bcnt
      always_ff @(posedge clk) begin
         if (rst) begin
            bcnt_reg[gi] <= '0;
         end else if (fire[gi] && (Latency > 1)) begin
            bcnt_reg[gi] <= CntW'(Latency - 1);
         end else if (bcnt_reg[gi] != '0) begin
            bcnt_reg[gi] <= bcnt_reg[gi] - CntW'(1);
         end
      end
   end

endmodule
